packet_ingress_arbiter: RTL and testbench
=========================================

Name: packet_ingress_arbiter

Overview:
Shares the single flit ingress of the packet reassembly buffer between NUM_PORTS flit sources (router input channels, local NI).
- Arbitration is round-robin at packet granularity. Once a port's HEAD flit is accepted, that port keeps the grant until its TAIL flit is accepted or a lock timeout fires.
- This guarantees the buffer never sees interleaved packets and prevents starvation across ports.
- Forwarding is a combinational pass-through: zero latency, no internal flit storage.

Parameters:
NUM_PORTS, 4, number of requesting flit sources (>=2)
LOCK_TIMEOUT, 64, idle cycles in LOCKED with no handshake from the locked port before the lock is released
CNT_WIDTH, 16, width of the drop and timeout statistics counters
PORT_W, $clog2(NUM_PORTS), derived; width of port indices

Ports:
nocclk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_flit[NUM_PORTS]  in  types::flit_t  per-port flit
in_valid  in  NUM_PORTS  per-port flit valid
in_ready  out  NUM_PORTS  per-port flit accepted (consumed) this cycle
out_flit  out  types::flit_t  flit to packet buffer (next_flit)
out_valid  out  1  to packet buffer next_flit_valid
out_ready  in  1  from packet buffer next_flit_ready
locked  out  1  1 while in LOCKED state
grant_port  out  PORT_W  port currently locked (valid when locked=1, else last granted)
drop_count  out  CNT_WIDTH  orphan BODY/TAIL flits discarded, saturating
timeout_count  out  CNT_WIDTH  lock timeouts, saturating

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE, rr_ptr=0, grant_port=0, lock_timer=0, drop_count=0, timeout_count=0. Outputs during/after reset: out_valid=0, in_ready=0, locked=0, out_flit='0.
- Handshake: a flit is transferred to the buffer when out_valid && out_ready. in_ready[p]=1 only for the single selected port and only when its flit is consumed (forwarded-and-accepted or dropped). in_ready is never asserted for more than one port in a cycle.
- IDLE selection:
  - sel = first p with in_valid[p]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_PORTS. Combinational.
  - If no port is valid: out_valid=0.
- IDLE actions by flit type of in_flit[sel]:
  - HEAD: out_flit=in_flit[sel], out_valid=1, in_ready[sel]=out_ready. On handshake: state->LOCKED, grant_port<=sel, lock_timer<=0.
  - BODY or TAIL (orphan): out_valid=0, in_ready[sel]=1. Flit is dropped; drop_count+1 (saturating); rr_ptr<=sel+1 mod N.
  - Any other type (system/nope): forwarded like HEAD but without locking. On handshake: rr_ptr<=sel+1 mod N, state stays IDLE.
- LOCKED (port g=grant_port):
  - Only port g is considered. out_flit=in_flit[g], out_valid=in_valid[g], in_ready[g]=in_valid[g]&out_ready. All other in_ready=0.
  - On any handshake: lock_timer<=0.
  - TAIL handshake: state->IDLE, rr_ptr<=g+1 mod N.
  - HEAD handshake (new packet without preceding tail): forwarded, stay LOCKED. The buffer expires the abandoned entry itself.
  - BODY/other handshake: stay LOCKED.
- Lock timeout:
  - In LOCKED, a cycle with no handshake increments lock_timer.
  - When lock_timer==LOCK_TIMEOUT-1 and no handshake occurs this cycle: state->IDLE, rr_ptr<=g+1 mod N, timeout_count+1 (saturating), lock_timer<=0.
  - A handshake in the same cycle as expiry wins: no timeout.
- Back-pressure: out_ready=0 in IDLE leaves rr_ptr and state unchanged. Selection may change next cycle if in_valid changes. Sources keep valid asserted until ready, per the standard valid/ready protocol.
- Wrap-around: rr_ptr is taken modulo NUM_PORTS. For non-power-of-two NUM_PORTS, wrap explicitly from NUM_PORTS-1 to 0.
- Counters stick at all-ones.
- Reset asserted mid-packet: immediate return to IDLE. Any partially forwarded packet is left for the buffer's expiry timer.

Test Plan:
- Reset mid-lock → out_valid=0, in_ready=0, locked=0 asynchronously; after release, the first HEAD from port 0 is granted with rr_ptr=0.
- Fairness: ports 0 and 2 each stream 3-flit packets (H,B,T) continuously, out_ready=1 → granted order 0,2,0,2; no interleaving; each packet occupies exactly 3 consecutive out handshakes.
- Lock hold: port 1 sends H, then in_valid[1]=0 for 10 cycles while port 3 has a HEAD pending → in_ready[3]=0 throughout; port 1's B,T then forwarded; port 3 granted in the cycle after T.
- Timeout: LOCK_TIMEOUT=8; port 0 sends H then stalls → locked drops after 8 idle cycles; timeout_count=1; port 1's pending HEAD is granted next.
- Orphan: port 2 presents BODY in IDLE → in_ready[2]=1, out_valid=0, drop_count=1. A drop_count preloaded to 0xFFFF stays at 0xFFFF.
- Back-pressure: out_ready=0 for 5 cycles during a locked BODY → in_ready=0, flit is held, lock_timer is not reset and no timeout occurs with LOCK_TIMEOUT=64; the transfer completes when out_ready=1.

Source files
------------

// File: rtl/packet_ingress_arbiter.sv
// Packet-granular round-robin arbiter sharing one flit ingress between NUM_PORTS sources.
// Forwarding is combinational; state is only the lock, rr pointer, lock timer and statistics.
package types;
    typedef enum logic [1:0] {
        FlitHead = 2'd0,
        FlitBody = 2'd1,
        FlitTail = 2'd2,
        FlitSys  = 2'd3
    } flit_type_e;

    typedef struct packed {
        flit_type_e  ftype;
        logic [29:0] payload;
    } flit_t;
endpackage

module packet_ingress_arbiter #(
    parameter int unsigned NUM_PORTS    = 4,
    parameter int unsigned LOCK_TIMEOUT = 64,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned PORT_W       = $clog2(NUM_PORTS)
) (
    input  logic                 nocclk,
    input  logic                 rst_n,
    input  types::flit_t         in_flit [NUM_PORTS],
    input  logic [NUM_PORTS-1:0] in_valid,
    output logic [NUM_PORTS-1:0] in_ready,
    output types::flit_t         out_flit,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 locked,
    output logic [PORT_W-1:0]    grant_port,
    output logic [CNT_WIDTH-1:0] drop_count,
    output logic [CNT_WIDTH-1:0] timeout_count
);
    localparam int unsigned TimerW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic {StIdle, StLocked} state_e;

    state_e               state_q, state_d;
    logic [PORT_W-1:0]    rr_q, rr_d;
    logic [PORT_W-1:0]    grant_q, grant_d;
    logic [TimerW-1:0]    timer_q, timer_d;
    logic [CNT_WIDTH-1:0] drop_q, drop_d;
    logic [CNT_WIDTH-1:0] to_q, to_d;
    logic [PORT_W-1:0]    sel;
    logic                 sel_valid;
    logic                 hs;

    // Explicit wrap so non-power-of-two port counts work.
    function automatic logic [PORT_W-1:0] next_port(input logic [PORT_W-1:0] p);
        if (p == PORT_W'(NUM_PORTS - 1)) begin
            return '0;
        end
        return p + PORT_W'(1);
    endfunction

    always_comb begin
        int unsigned idx;
        sel       = rr_q;
        sel_valid = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            idx = (32'(rr_q) + i) % NUM_PORTS;
            if (!sel_valid && in_valid[PORT_W'(idx)]) begin
                sel_valid = 1'b1;
                sel       = PORT_W'(idx);
            end
        end
    end

    always_comb begin
        out_flit  = '0;
        out_valid = 1'b0;
        in_ready  = '0;
        hs        = 1'b0;
        state_d   = state_q;
        rr_d      = rr_q;
        grant_d   = grant_q;
        timer_d   = timer_q;
        drop_d    = drop_q;
        to_d      = to_q;
        // Outputs stay quiet while reset is held, whatever the sources present.
        if (rst_n) begin
            unique case (state_q)
                StIdle: begin
                    if (sel_valid) begin
                        if (in_flit[sel].ftype inside {types::FlitBody, types::FlitTail}) begin
                            in_ready[sel] = 1'b1;
                            rr_d          = next_port(sel);
                            if (drop_q != '1) begin
                                drop_d = drop_q + CNT_WIDTH'(1);
                            end
                        end else begin
                            out_flit      = in_flit[sel];
                            out_valid     = 1'b1;
                            in_ready[sel] = out_ready;
                            if (out_ready) begin
                                if (in_flit[sel].ftype == types::FlitHead) begin
                                    state_d = StLocked;
                                    grant_d = sel;
                                    timer_d = '0;
                                end else begin
                                    rr_d = next_port(sel);
                                end
                            end
                        end
                    end
                end
                StLocked: begin
                    out_flit          = in_flit[grant_q];
                    out_valid         = in_valid[grant_q];
                    hs                = in_valid[grant_q] & out_ready;
                    in_ready[grant_q] = hs;
                    if (hs) begin
                        timer_d = '0;
                        if (in_flit[grant_q].ftype == types::FlitTail) begin
                            state_d = StIdle;
                            rr_d    = next_port(grant_q);
                        end
                    end else if (timer_q == TimerW'(LOCK_TIMEOUT - 1)) begin
                        state_d = StIdle;
                        rr_d    = next_port(grant_q);
                        timer_d = '0;
                        if (to_q != '1) begin
                            to_d = to_q + CNT_WIDTH'(1);
                        end
                    end else begin
                        timer_d = timer_q + TimerW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rr_q    <= '0;
            grant_q <= '0;
            timer_q <= '0;
            drop_q  <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            timer_q <= timer_d;
            drop_q  <= drop_d;
            to_q    <= to_d;
        end
    end

    assign locked        = (state_q == StLocked);
    assign grant_port    = grant_q;
    assign drop_count    = drop_q;
    assign timeout_count = to_q;

endmodule

// File: tb/tb_packet_ingress_arbiter.sv
// Bench for packet_ingress_arbiter: two instances (lock timeout 8 / 64, counters 16 / 2 bits)
// share the stimulus and are both checked every cycle against a packet-level model.
module tb_packet_ingress_arbiter;
    import types::*;

    localparam int N = 4;

    logic        nocclk = 1'b0;
    logic        rst_n  = 1'b0;
    flit_t       in_flit [N];
    logic [3:0]  in_valid  = '0;
    logic        out_ready = 1'b1;

    logic [3:0]  rdy_a  [2];
    flit_t       flit_a [2];
    logic        val_a  [2];
    logic        lck_a  [2];
    logic [1:0]  gnt_a  [2];
    logic [15:0] drop0, to0;
    logic [1:0]  drop1, to1;

    always #5 nocclk = ~nocclk;

    packet_ingress_arbiter #(.NUM_PORTS(4), .LOCK_TIMEOUT(8), .CNT_WIDTH(16)) dut0 (
        .nocclk(nocclk), .rst_n(rst_n), .in_flit(in_flit), .in_valid(in_valid),
        .in_ready(rdy_a[0]), .out_flit(flit_a[0]), .out_valid(val_a[0]), .out_ready(out_ready),
        .locked(lck_a[0]), .grant_port(gnt_a[0]), .drop_count(drop0), .timeout_count(to0)
    );

    packet_ingress_arbiter #(.NUM_PORTS(4), .LOCK_TIMEOUT(64), .CNT_WIDTH(2)) dut1 (
        .nocclk(nocclk), .rst_n(rst_n), .in_flit(in_flit), .in_valid(in_valid),
        .in_ready(rdy_a[1]), .out_flit(flit_a[1]), .out_valid(val_a[1]), .out_ready(out_ready),
        .locked(lck_a[1]), .grant_port(gnt_a[1]), .drop_count(drop1), .timeout_count(to1)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic [1:0] pi(input int p);
        return 2'(p);
    endfunction

    function automatic flit_t mk(input flit_type_e t, input int pl);
        flit_t f;
        f.ftype   = t;
        f.payload = 30'(pl);
        return f;
    endfunction

    function automatic int to_of(input int k);
        return (k == 0) ? 8 : 64;
    endfunction

    function automatic int max_of(input int k);
        return (k == 0) ? 65535 : 3;
    endfunction

    // Source queues; the driving DUT (drv_k) decides which flits are consumed.
    flit_t src_q [N][$];
    int    drv_k = 0;
    logic [3:0] cons = '0;

    typedef struct {int port; int ft; int cyc;} ev_t;
    ev_t log_q[$];
    int  base = 0;
    int  cyc  = 0;

    // Model state per instance: packet lock, rr pointer, grant, idle count, counters.
    int m_lck [2] = '{0, 0};
    int m_rr  [2] = '{0, 0};
    int m_g   [2] = '{0, 0};
    int m_tmr [2] = '{0, 0};
    int m_drop[2] = '{0, 0};
    int m_to  [2] = '{0, 0};

    always @(negedge nocclk) begin
        logic       k1;
        logic [3:0] er;
        logic       ev;
        flit_t      ef;
        int         sel, g;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            k1 = 1'(k);
            if (!rst_n) begin
                m_lck[k1] = 0; m_rr[k1] = 0; m_g[k1] = 0;
                m_tmr[k1] = 0; m_drop[k1] = 0; m_to[k1] = 0;
                chk("rst_out_valid", 64'(val_a[k1]), 64'(0));
                chk("rst_in_ready", 64'(rdy_a[k1]), 64'(0));
                chk("rst_locked", 64'(lck_a[k1]), 64'(0));
                chk("rst_out_flit", 64'(flit_a[k1]), 64'(0));
            end else begin
                chk("locked", 64'(lck_a[k1]), 64'(m_lck[k1]));
                chk("grant_port", 64'(gnt_a[k1]), 64'(m_g[k1]));
                chk("drop_count", (k == 0) ? 64'(drop0) : 64'(drop1), 64'(m_drop[k1]));
                chk("timeout_count", (k == 0) ? 64'(to0) : 64'(to1), 64'(m_to[k1]));
                ev = 1'b0; er = '0; ef = '0;
                if (m_lck[k1] == 0) begin
                    sel = -1;
                    for (int i = 0; i < N; i++)
                        if (sel < 0 && in_valid[pi((m_rr[k1] + i) % N)]) sel = (m_rr[k1] + i) % N;
                    if (sel >= 0) begin
                        if (in_flit[pi(sel)].ftype == FlitBody ||
                            in_flit[pi(sel)].ftype == FlitTail) begin
                            er[pi(sel)] = 1'b1;
                            if (m_drop[k1] < max_of(k)) m_drop[k1]++;
                            m_rr[k1] = (sel + 1) % N;
                        end else begin
                            ev = 1'b1;
                            ef = in_flit[pi(sel)];
                            er[pi(sel)] = out_ready;
                            if (out_ready) begin
                                if (in_flit[pi(sel)].ftype == FlitHead) begin
                                    m_lck[k1] = 1; m_g[k1] = sel; m_tmr[k1] = 0;
                                end else begin
                                    m_rr[k1] = (sel + 1) % N;
                                end
                            end
                        end
                    end
                end else begin
                    g  = m_g[k1];
                    ev = in_valid[pi(g)];
                    ef = in_flit[pi(g)];
                    er[pi(g)] = in_valid[pi(g)] & out_ready;
                    if (er[pi(g)]) begin
                        m_tmr[k1] = 0;
                        if (in_flit[pi(g)].ftype == FlitTail) begin
                            m_lck[k1] = 0; m_rr[k1] = (g + 1) % N;
                        end
                    end else begin
                        m_tmr[k1]++;
                        if (m_tmr[k1] == to_of(k)) begin
                            m_lck[k1] = 0; m_rr[k1] = (g + 1) % N; m_tmr[k1] = 0;
                            if (m_to[k1] < max_of(k)) m_to[k1]++;
                        end
                    end
                end
                chk("in_ready", 64'(rdy_a[k1]), 64'(er));
                chk("out_valid", 64'(val_a[k1]), 64'(ev));
                if (ev) chk("out_flit", 64'(flit_a[k1]), 64'(ef));
            end
        end
        k1 = 1'(drv_k);
        cons = rst_n ? rdy_a[k1] : '0;
        if (rst_n && val_a[k1] && out_ready)
            for (int p = 0; p < N; p++)
                if (rdy_a[k1][pi(p)]) log_q.push_back('{p, int'(flit_a[k1].ftype), cyc});
    end

    task automatic drive();
        for (int p = 0; p < N; p++) begin
            in_valid[pi(p)] = (src_q[pi(p)].size() > 0);
            in_flit[pi(p)]  = (src_q[pi(p)].size() > 0) ? src_q[pi(p)][0] : '0;
        end
    endtask

    task automatic step();
        @(posedge nocclk);
        #1;
        for (int p = 0; p < N; p++)
            if (cons[pi(p)]) void'(src_q[pi(p)].pop_front());
        drive();
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int p = 0; p < N; p++) src_q[pi(p)].delete();
        out_ready = 1'b1;
        drive();
        repeat (2) @(posedge nocclk);
        #1 rst_n = 1'b1;
        #2;
        base = log_q.size();
    endtask

    task automatic chk_log(input string nm, input int i, input int port, input int ft);
        if (log_q.size() > base + i) begin
            chk({nm, "_port"}, 64'(log_q[base + i].port), 64'(port));
            chk({nm, "_type"}, 64'(log_q[base + i].ft), 64'(ft));
        end else begin
            chk({nm, "_present"}, 64'(log_q.size() - base), 64'(i + 1));
        end
    endtask

    function automatic int cyc_of(input int i);
        return (log_q.size() > base + i) ? log_q[base + i].cyc : -1000;
    endfunction

    initial begin
        for (int p = 0; p < N; p++) in_flit[pi(p)] = '0;

        // Fairness: ports 0 and 2 stream H,B,T packets back to back.
        drv_k = 0;
        do_reset();
        for (int n = 0; n < 2; n++) begin
            src_q[0].push_back(mk(FlitHead, 'h100 + n)); src_q[0].push_back(mk(FlitBody, 'h110));
            src_q[0].push_back(mk(FlitTail, 'h120));     src_q[2].push_back(mk(FlitHead, 'h200 + n));
            src_q[2].push_back(mk(FlitBody, 'h210));     src_q[2].push_back(mk(FlitTail, 'h220));
        end
        drive();
        repeat (14) step();
        chk("fair_count", 64'(log_q.size() - base), 64'(12));
        for (int i = 0; i < 12; i++) chk_log("fair", i, ((i / 3) % 2 == 0) ? 0 : 2, i % 3);
        chk("fair_back_to_back", 64'(cyc_of(11) - cyc_of(0)), 64'(11));

        // Reset mid-lock, then rr restarts at port 0 although port 3 also requests.
        do_reset();
        src_q[0].push_back(mk(FlitHead, 'h300)); src_q[0].push_back(mk(FlitBody, 'h301));
        src_q[0].push_back(mk(FlitTail, 'h302));
        drive();
        step();
        chk("pre_reset_locked", 64'(lck_a[0]), 64'(1));
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("async_rst_valid", 64'(val_a[1'(k)]), 64'(0));
            chk("async_rst_ready", 64'(rdy_a[1'(k)]), 64'(0));
            chk("async_rst_locked", 64'(lck_a[1'(k)]), 64'(0));
        end
        for (int p = 0; p < N; p++) src_q[pi(p)].delete();
        drive();
        repeat (2) @(posedge nocclk);
        #1 rst_n = 1'b1;
        #2;
        base = log_q.size();
        src_q[3].push_back(mk(FlitHead, 'h330)); src_q[0].push_back(mk(FlitHead, 'h310));
        drive();
        repeat (2) step();
        chk_log("post_reset_grant", 0, 0, 0);

        // Lock hold on port 1 (64-cycle timeout instance drives).
        drv_k = 1;
        do_reset();
        src_q[1].push_back(mk(FlitHead, 'h410)); src_q[3].push_back(mk(FlitHead, 'h430));
        drive();
        repeat (11) step();
        chk("hold_locked", 64'(lck_a[1]), 64'(1));
        chk("hold_grant", 64'(gnt_a[1]), 64'(1));
        chk("hold_ready", 64'(rdy_a[1]), 64'(0));
        src_q[1].push_back(mk(FlitBody, 'h411)); src_q[1].push_back(mk(FlitTail, 'h412));
        drive();
        repeat (4) step();
        chk_log("hold_h", 0, 1, 0);
        chk_log("hold_b", 1, 1, 1);
        chk_log("hold_t", 2, 1, 2);
        chk_log("hold_next", 3, 3, 0);
        chk("hold_gap", 64'(cyc_of(1) - cyc_of(0)), 64'(11));
        chk("hold_next_cycle", 64'(cyc_of(3) - cyc_of(2)), 64'(1));

        // Timeout: port 0 stalls after HEAD on the 8-cycle instance.
        drv_k = 0;
        do_reset();
        src_q[0].push_back(mk(FlitHead, 'h500)); src_q[1].push_back(mk(FlitHead, 'h510));
        drive();
        repeat (12) step();
        chk_log("to_first", 0, 0, 0);
        chk_log("to_next", 1, 1, 0);
        chk("to_gap", 64'(cyc_of(1) - cyc_of(0)), 64'(9));
        chk("to_count8", 64'(to0), 64'(1));
        chk("to_count64", 64'(to1), 64'(0));
        chk("to_still_locked64", 64'(lck_a[1]), 64'(1));

        // Orphans in IDLE are dropped; the 2-bit counter saturates.
        do_reset();
        for (int i = 0; i < 5; i++) src_q[2].push_back(mk((i < 3) ? FlitBody : FlitTail, 'h600 + i));
        drive();
        #1;
        chk("orphan_ready", 64'(rdy_a[0]), 64'(4'b0100));
        chk("orphan_valid", 64'(val_a[0]), 64'(0));
        repeat (6) step();
        chk("orphan_drops16", 64'(drop0), 64'(5));
        chk("orphan_drops_sat", 64'(drop1), 64'(3));

        // Back-pressure during a locked BODY.
        drv_k = 1;
        do_reset();
        src_q[0].push_back(mk(FlitHead, 'h700)); src_q[0].push_back(mk(FlitBody, 'h701));
        src_q[0].push_back(mk(FlitTail, 'h702));
        drive();
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ready", 64'(rdy_a[1]), 64'(0));
            chk("bp_held_flit", 64'(flit_a[1]), 64'(mk(FlitBody, 'h701)));
            step();
        end
        out_ready = 1'b1;
        repeat (3) step();
        chk_log("bp_h", 0, 0, 0);
        chk_log("bp_b", 1, 0, 1);
        chk_log("bp_t", 2, 0, 2);
        chk("bp_gap", 64'(cyc_of(1) - cyc_of(0)), 64'(6));
        chk("bp_no_timeout", 64'(to1), 64'(0));
        chk("bp_no_timeout8", 64'(to0), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
